// File: rtl/retire_unit_pkg.sv
// ============================================================================
// retire_unit_pkg : shared types and sizes for the in-order commit stage
// Rev 1.0
// ============================================================================
`default_nettype none

package retire_unit_pkg;

   localparam int N_LANES           = 4;
   localparam int ARCH_REG_COUNT    = 32;
   localparam int PHYS_REG_SZ_R10K  = 64;
   localparam int ROB_SZ            = 32;
   localparam int ADDR_W            = 32;
   localparam int ARCH_AR_W         = $clog2(ARCH_REG_COUNT);
   localparam int PHYS_PR_W         = (PHYS_REG_SZ_R10K > 1) ? $clog2(PHYS_REG_SZ_R10K) : 1;
   localparam int ROB_IDX_W         = $clog2(ROB_SZ);

   typedef logic [ROB_IDX_W-1:0] rob_idx_t;
   typedef logic [ADDR_W-1:0]    addr_t;

   typedef struct packed {
      logic                  complete;
      logic                  has_dest;
      logic [ARCH_AR_W-1:0]  dest_ar;
      logic [PHYS_PR_W-1:0]  Tnew;
      logic [PHYS_PR_W-1:0]  Told;
      logic                  is_store;
      logic                  halt;
      logic                  pred_taken;
      logic                  branch_taken;
      addr_t                 pred_target;
      addr_t                 branch_target;
      addr_t                 pc;
      rob_idx_t              rob_idx;
   } rob_entry_t;

   typedef enum logic [1:0] {
      NORMAL  = 2'd0,
      RECOVER = 2'd1,
      HALTED  = 2'd2
   } retire_state_e;

   typedef enum logic [2:0] {
      STOP_NONE       = 3'd0,
      STOP_INCOMPLETE = 3'd1,
      STOP_STORE      = 3'd2,
      STOP_MISPRED    = 3'd3,
      STOP_HALT       = 3'd4
   } stop_reason_e;

   function automatic logic is_mispredict(input rob_entry_t e);
      return (e.pred_taken != e.branch_taken) ||
             (e.branch_taken && (e.pred_target != e.branch_target));
   endfunction

endpackage

`default_nettype wire

// File: rtl/retire_unit_if.sv
// ============================================================================
// retire_unit_if : head window, store handshake and commit-side outputs
// Rev 1.0
// ============================================================================
`default_nettype none

interface retire_unit_if #(
   parameter int N   = retire_unit_pkg::N_LANES,
   parameter int ARW = retire_unit_pkg::ARCH_AR_W,
   parameter int PRW = retire_unit_pkg::PHYS_PR_W,
   parameter int CW  = $clog2(N + 1)
);
   import retire_unit_pkg::*;

   rob_entry_t [N-1:0]          head_entries;
   logic [N-1:0]                head_valids;
   logic                        sq_ready;
   logic [CW-1:0]               retire_count;
   logic [N-1:0]                Arch_Retire_EN;
   logic [N-1:0][ARW-1:0]       Arch_Retire_AR;
   logic [N-1:0][PRW-1:0]       Arch_Tnew_in;
   logic [N-1:0]                FL_RetireEN;
   logic [N-1:0][PRW-1:0]       FL_RetireReg;
   logic [N-1:0]                sq_commit_en;
   logic                        rob_mispredict;
   logic                        BPRecoverEN;
   rob_idx_t                    rob_mispred_idx;
   addr_t                       redirect_pc;
   logic                        halted;
   logic [63:0]                 retired_insts;
   logic [31:0]                 mispred_cnt;

   modport master (
      input  head_entries, head_valids, sq_ready,
      output retire_count, Arch_Retire_EN, Arch_Retire_AR, Arch_Tnew_in,
             FL_RetireEN, FL_RetireReg, sq_commit_en, rob_mispredict,
             BPRecoverEN, rob_mispred_idx, redirect_pc, halted,
             retired_insts, mispred_cnt
   );

   modport slave (
      output head_entries, head_valids, sq_ready,
      input  retire_count, Arch_Retire_EN, Arch_Retire_AR, Arch_Tnew_in,
             FL_RetireEN, FL_RetireReg, sq_commit_en, rob_mispredict,
             BPRecoverEN, rob_mispred_idx, redirect_pc, halted,
             retired_insts, mispred_cnt
   );

endinterface

`default_nettype wire

// File: rtl/retire_unit_select.sv
// ============================================================================
// retire_unit_select : oldest-first walk of the head window -> take mask
// Rev 1.0
// ============================================================================
`default_nettype none

module retire_unit_select
   import retire_unit_pkg::*;
#(
   parameter int N      = N_LANES,
   parameter int MAX_ST = 1,
   parameter int LW     = (N > 1) ? $clog2(N) : 1
) (
   input  logic               enable,
   input  rob_entry_t [N-1:0] entries,
   input  logic [N-1:0]       valids,
   input  logic               sq_ready,
   output logic [N-1:0]       take,
   output stop_reason_e       stop_reason,
   output logic [LW-1:0]      stop_lane
);

   always_comb begin
      int   n_st;
      logic done;
      take        = '0;
      stop_reason = STOP_NONE;
      stop_lane   = '0;
      n_st        = 0;
      done        = 1'b0;
      // Lane N-1 is oldest; invalid lanes are holes and do not end the walk.
      for (int i = N - 1; i >= 0; i--) begin
         if (enable && !done && valids[i]) begin
            if (!entries[i].complete) begin
               done        = 1'b1;
               stop_reason = STOP_INCOMPLETE;
               stop_lane   = LW'(i);
            end else if (entries[i].is_store && ((n_st >= MAX_ST) || !sq_ready)) begin
               done        = 1'b1;
               stop_reason = STOP_STORE;
               stop_lane   = LW'(i);
            end else begin
               take[i] = 1'b1;
               if (entries[i].is_store) begin
                  n_st = n_st + 1;
               end
               if (is_mispredict(entries[i])) begin
                  done        = 1'b1;
                  stop_reason = STOP_MISPRED;
                  stop_lane   = LW'(i);
               end else if (entries[i].halt) begin
                  done        = 1'b1;
                  stop_reason = STOP_HALT;
                  stop_lane   = LW'(i);
               end
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/retire_unit.sv
// ============================================================================
// retire_unit : in-order commit stage with recovery FSM and perf counters
// Rev 1.0
// ============================================================================
`default_nettype none

module retire_unit
   import retire_unit_pkg::*;
#(
   parameter int N              = N_LANES,
   parameter int ARCH_COUNT     = ARCH_REG_COUNT,
   parameter int PHYS_REGS      = PHYS_REG_SZ_R10K,
   parameter int MAX_ST         = 1,
   parameter int RECOVER_CYCLES = 2
) (
   input  logic          clock,
   input  logic          reset,
   retire_unit_if.master rif
);

   localparam int ARW = $clog2(ARCH_COUNT);
   localparam int PRW = (PHYS_REGS > 1) ? $clog2(PHYS_REGS) : 1;
   localparam int CW  = $clog2(N + 1);
   localparam int LW  = (N > 1) ? $clog2(N) : 1;
   localparam int RCW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES + 1) : 1;

   retire_state_e  state_q, state_d;
   logic [RCW-1:0] rec_cnt_q, rec_cnt_d;
   logic           pulse_q, pulse_d;
   rob_idx_t       idx_q, idx_d;
   addr_t          redirect_q, redirect_d;
   logic           halted_q, halted_d;
   logic [63:0]    retired_q, retired_d;
   logic [31:0]    mcnt_q, mcnt_d;

   logic [N-1:0]   take;
   stop_reason_e   stop_reason;
   logic [LW-1:0]  stop_lane;
   logic [CW-1:0]  count;
   rob_entry_t     stop_entry;
   logic           mispred_take;
   logic           halt_take;

   // Holding reset low also forces every combinational commit output to 0.
   retire_unit_select #(
      .N      (N),
      .MAX_ST (MAX_ST),
      .LW     (LW)
   ) u_select (
      .enable      (reset && (state_q == NORMAL)),
      .entries     (rif.head_entries),
      .valids      (rif.head_valids),
      .sq_ready    (rif.sq_ready),
      .take        (take),
      .stop_reason (stop_reason),
      .stop_lane   (stop_lane)
   );

   assign stop_entry   = rif.head_entries[stop_lane];
   assign mispred_take = (stop_reason == STOP_MISPRED);
   assign halt_take    = (stop_reason == STOP_HALT);

   always_comb begin
      rif.Arch_Retire_EN = '0;
      rif.Arch_Retire_AR = '0;
      rif.Arch_Tnew_in   = '0;
      rif.FL_RetireEN    = '0;
      rif.FL_RetireReg   = '0;
      rif.sq_commit_en   = '0;
      count              = '0;
      for (int i = 0; i < N; i++) begin
         count = count + CW'(take[i]);
         if (take[i] && rif.head_entries[i].has_dest) begin
            rif.Arch_Retire_EN[i] = 1'b1;
            rif.Arch_Retire_AR[i] = ARW'(rif.head_entries[i].dest_ar);
            rif.Arch_Tnew_in[i]   = PRW'(rif.head_entries[i].Tnew);
            // Architectural r0 never owns a physical register worth freeing.
            if (rif.head_entries[i].dest_ar != '0) begin
               rif.FL_RetireEN[i]  = 1'b1;
               rif.FL_RetireReg[i] = PRW'(rif.head_entries[i].Told);
            end
         end
         if (take[i] && rif.head_entries[i].is_store) begin
            rif.sq_commit_en[i] = 1'b1;
         end
      end
   end

   assign rif.retire_count = count;

   always_comb begin
      state_d    = state_q;
      rec_cnt_d  = rec_cnt_q;
      pulse_d    = 1'b0;
      idx_d      = idx_q;
      redirect_d = redirect_q;
      halted_d   = halted_q;
      retired_d  = retired_q + 64'(count);
      mcnt_d     = mcnt_q + {31'd0, mispred_take};
      case (state_q)
         NORMAL: begin
            if (mispred_take) begin
               state_d    = RECOVER;
               rec_cnt_d  = RCW'(RECOVER_CYCLES - 1);
               pulse_d    = 1'b1;
               idx_d      = stop_entry.rob_idx;
               redirect_d = stop_entry.branch_taken ? stop_entry.branch_target
                                                    : stop_entry.pc + 32'd4;
            end else if (halt_take) begin
               state_d  = HALTED;
               halted_d = 1'b1;
            end
         end
         RECOVER: begin
            if (rec_cnt_q == '0) begin
               state_d = NORMAL;
            end else begin
               rec_cnt_d = rec_cnt_q - 1'b1;
            end
         end
         HALTED:  state_d = HALTED;
         default: state_d = NORMAL;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= NORMAL;
         rec_cnt_q  <= '0;
         pulse_q    <= 1'b0;
         idx_q      <= '0;
         redirect_q <= '0;
         halted_q   <= 1'b0;
         retired_q  <= '0;
         mcnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         rec_cnt_q  <= rec_cnt_d;
         pulse_q    <= pulse_d;
         idx_q      <= idx_d;
         redirect_q <= redirect_d;
         halted_q   <= halted_d;
         retired_q  <= retired_d;
         mcnt_q     <= mcnt_d;
      end
   end

   assign rif.rob_mispredict  = pulse_q;
   assign rif.BPRecoverEN     = pulse_q;
   assign rif.rob_mispred_idx = idx_q;
   assign rif.redirect_pc     = redirect_q;
   assign rif.halted          = halted_q;
   assign rif.retired_insts   = retired_q;
   assign rif.mispred_cnt     = mcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_retire_unit.sv
// ============================================================================
// tb_retire_unit : directed scenarios plus randomized windows vs a reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_retire_unit;
   import retire_unit_pkg::*;

   localparam int N   = 4;
   localparam int ARW = 5;
   localparam int PRW = 6;
   localparam int CW  = $clog2(N + 1);
   localparam int MAX_ST = 1;
   localparam int RECOVER_CYCLES = 2;

   logic clk;
   logic rst_n;

   rob_entry_t [N-1:0] win_e;
   logic [N-1:0]       win_v;
   logic               sq_rdy;

   int n_tests;
   int n_fail;

   // reference model state: mode 0 normal, 1 recovering, 2 halted
   int          m_mode;
   int          m_rec_left;
   logic        m_pulse;
   logic [31:0] m_redir;
   logic [4:0]  m_idx;
   logic        m_halted;
   logic [63:0] m_retired;
   logic [31:0] m_mcnt;

   retire_unit_if #(.N(N), .ARW(ARW), .PRW(PRW), .CW(CW)) rif ();

   assign rif.head_entries = win_e;
   assign rif.head_valids  = win_v;
   assign rif.sq_ready     = sq_rdy;

   retire_unit #(
      .N              (N),
      .ARCH_COUNT     (32),
      .PHYS_REGS      (64),
      .MAX_ST         (MAX_ST),
      .RECOVER_CYCLES (RECOVER_CYCLES)
   ) dut (
      .clock (clk),
      .reset (rst_n),
      .rif   (rif.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode     = 0;
      m_rec_left = 0;
      m_pulse    = 1'b0;
      m_redir    = '0;
      m_idx      = '0;
      m_halted   = 1'b0;
      m_retired  = '0;
      m_mcnt     = '0;
   endtask

   function automatic rob_entry_t mk_alu(input int ar);
      rob_entry_t e;
      e          = '0;
      e.complete = 1'b1;
      e.has_dest = 1'b1;
      e.dest_ar  = 5'(ar);
      e.Tnew     = 6'($urandom);
      e.Told     = 6'($urandom);
      e.pc       = 32'($urandom) & 32'hFFFF_FFFC;
      e.rob_idx  = 5'($urandom);
      return e;
   endfunction

   function automatic rob_entry_t mk_rand();
      rob_entry_t e;
      e          = mk_alu(int'($urandom_range(0, 31)));
      e.complete = ($urandom_range(0, 9) != 0);
      e.has_dest = ($urandom_range(0, 3) != 0);
      e.is_store = ($urandom_range(0, 4) == 0);
      e.halt     = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) begin
         e.pred_taken    = 1'($urandom);
         e.branch_taken  = 1'($urandom);
         e.branch_target = 32'($urandom);
         e.pred_target   = ($urandom_range(0, 1) == 1) ? e.branch_target : 32'($urandom);
      end
      return e;
   endfunction

   task automatic all_alu();
      for (int l = 0; l < N; l++) win_e[l] = mk_alu(l + 1);
      win_v = '1;
   endtask

   // Compare every output for the current cycle, then step the model past the next edge.
   task automatic check_cycle();
      int lanes[$];
      int taken[$];
      int n_st;
      int l;
      logic mp, hl;
      rob_entry_t e, mpe;
      logic [N-1:0] e_aen, e_flen, e_sq;
      logic [N-1:0][ARW-1:0] e_aar;
      logic [N-1:0][PRW-1:0] e_tn, e_fl;
      #1;
      n_st = 0; mp = 1'b0; hl = 1'b0; mpe = '0;
      e_aen = '0; e_flen = '0; e_sq = '0; e_aar = '0; e_tn = '0; e_fl = '0;
      if (rst_n && m_mode == 0) begin
         for (int k = N - 1; k >= 0; k--) if (win_v[k]) lanes.push_back(k);
         for (int k = 0; k < lanes.size(); k++) begin
            e = win_e[lanes[k]];
            if (!e.complete) break;
            if (e.is_store && (n_st == MAX_ST || !sq_rdy)) break;
            taken.push_back(lanes[k]);
            if (e.is_store) n_st++;
            if (e.pred_taken != e.branch_taken ||
                (e.branch_taken && e.pred_target != e.branch_target)) begin
               mp = 1'b1; mpe = e; break;
            end
            if (e.halt) begin hl = 1'b1; break; end
         end
      end
      foreach (taken[k]) begin
         l = taken[k];
         if (win_e[l].has_dest) begin
            e_aen[l] = 1'b1; e_aar[l] = win_e[l].dest_ar; e_tn[l] = win_e[l].Tnew;
            if (win_e[l].dest_ar != 0) begin e_flen[l] = 1'b1; e_fl[l] = win_e[l].Told; end
         end
         if (win_e[l].is_store) e_sq[l] = 1'b1;
      end
      check("retire_count", 64'(rif.retire_count), 64'(taken.size()));
      check("arch_en",      64'(rif.Arch_Retire_EN), 64'(e_aen));
      check("arch_ar",      64'(rif.Arch_Retire_AR), 64'(e_aar));
      check("arch_tnew",    64'(rif.Arch_Tnew_in),   64'(e_tn));
      check("fl_en",        64'(rif.FL_RetireEN),    64'(e_flen));
      check("fl_reg",       64'(rif.FL_RetireReg),   64'(e_fl));
      check("sq_commit",    64'(rif.sq_commit_en),   64'(e_sq));
      check("rob_mispredict", 64'(rif.rob_mispredict), 64'(m_pulse));
      check("bp_recover",   64'(rif.BPRecoverEN),    64'(m_pulse));
      check("mispred_idx",  64'(rif.rob_mispred_idx), 64'(m_idx));
      check("redirect_pc",  64'(rif.redirect_pc),    64'(m_redir));
      check("halted",       64'(rif.halted),         64'(m_halted));
      check("retired_insts", rif.retired_insts,      m_retired);
      check("mispred_cnt",  64'(rif.mispred_cnt),    64'(m_mcnt));
      if (rst_n) begin
         m_retired = m_retired + 64'(taken.size());
         m_pulse   = 1'b0;
         if (m_mode == 1) begin
            m_rec_left--;
            if (m_rec_left == 0) m_mode = 0;
         end else if (m_mode == 0) begin
            if (mp) begin
               m_mode     = 1;
               m_rec_left = RECOVER_CYCLES;
               m_pulse    = 1'b1;
               m_idx      = mpe.rob_idx;
               m_redir    = mpe.branch_taken ? mpe.branch_target : mpe.pc + 32'd4;
               m_mcnt     = m_mcnt + 32'd1;
            end else if (hl) begin
               m_mode   = 2;
               m_halted = 1'b1;
            end
         end
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      sq_rdy  = 1'b1;
      win_e   = '0;
      win_v   = '0;
      model_reset();

      @(negedge clk); all_alu(); check_cycle();
      @(negedge clk); rst_n = 1'b1;

      // all complete ALU ops, dest 5,0,7,9 in lanes 3..0
      win_e[3] = mk_alu(5); win_e[2] = mk_alu(0); win_e[1] = mk_alu(7); win_e[0] = mk_alu(9);
      win_v = '1;
      check_cycle();
      check("tp_all_count", 64'(rif.retire_count), 64'd4);
      check("tp_all_fl_en", 64'(rif.FL_RetireEN), 64'b1011);

      @(negedge clk); win_e[2].complete = 1'b0; check_cycle();
      check("tp_incomplete_count", 64'(rif.retire_count), 64'd1);
      check("tp_retired_4", rif.retired_insts, 64'd4);

      // mispredicted branch in lane 2
      @(negedge clk); all_alu();
      win_e[2].branch_taken = 1'b1; win_e[2].branch_target = 32'h100;
      check_cycle();
      check("tp_mp_count", 64'(rif.retire_count), 64'd2);
      @(negedge clk); all_alu(); check_cycle();
      check("tp_mp_pulse", 64'(rif.rob_mispredict), 64'd1);
      check("tp_mp_redirect", 64'(rif.redirect_pc), 64'h100);
      check("tp_mp_recover1", 64'(rif.retire_count), 64'd0);
      @(negedge clk); all_alu(); check_cycle();
      check("tp_mp_recover2", 64'(rif.retire_count), 64'd0);
      @(negedge clk); all_alu(); check_cycle();
      check("tp_mp_resume", 64'(rif.retire_count), 64'd4);

      // two stores with one store slot per cycle
      @(negedge clk); all_alu(); win_e[3].is_store = 1'b1; win_e[1].is_store = 1'b1;
      check_cycle();
      check("tp_st_commit", 64'(rif.sq_commit_en), 64'b1000);
      @(negedge clk); sq_rdy = 1'b0; check_cycle();
      check("tp_st_blocked", 64'(rif.retire_count), 64'd0);

      // halt in lane 1
      @(negedge clk); sq_rdy = 1'b1; all_alu(); win_e[1].halt = 1'b1; check_cycle();
      check("tp_halt_count", 64'(rif.retire_count), 64'd3);
      @(negedge clk); all_alu(); check_cycle();
      check("tp_halted", 64'(rif.halted), 64'd1);

      // reset during the first recovery cycle
      @(negedge clk); rst_n = 1'b0; model_reset(); check_cycle();
      @(negedge clk); rst_n = 1'b1; all_alu(); win_e[3].pred_taken = 1'b1; check_cycle();
      @(negedge clk); rst_n = 1'b0; model_reset(); all_alu(); check_cycle();
      check("tp_rst_pulse", 64'(rif.rob_mispredict), 64'd0);
      @(negedge clk); rst_n = 1'b1; check_cycle();
      check("tp_rst_resume", 64'(rif.retire_count), 64'd4);

      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 24) == 0) begin
            rst_n = 1'b0;
            model_reset();
         end else begin
            rst_n = 1'b1;
         end
         for (int l = 0; l < N; l++) win_e[l] = mk_rand();
         win_v  = 4'($urandom);
         sq_rdy = ($urandom_range(0, 3) != 0);
         check_cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
